// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Receive-side checker for the one-hot traffic-light bus (RED=100, GREEN=010,
// YELLOW=001). It samples the bus every clock and tracks the current phase and
// how long it has lasted. It counts completed RED->GREEN->YELLOW cycles and
// flags encoding, ordering and dwell-time violations. All outputs are
// registered and reflect the bus value sampled at the previous rising edge.
// The phase output doubles as the FSM state for debug and checker binding.
module traffic_light_monitor #(
  parameter int CNT_W      = 4,
  parameter int MIN_RED    = 1,
  parameter int MIN_GREEN  = 1,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_DWELL  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [7:0]       cycle_cnt,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } phase_t;

  localparam logic [CNT_W-1:0] DWELL_SAT    = '1;
  localparam logic [CNT_W-1:0] MIN_RED_C    = CNT_W'(MIN_RED);
  localparam logic [CNT_W-1:0] MIN_GREEN_C  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
  // One wider than the counter so the first step past MAX_DWELL is visible
  // even when MAX_DWELL sits at the saturation value.
  localparam logic [CNT_W:0]   MAX_P1       = (CNT_W+1)'(MAX_DWELL + 1);

  phase_t           state;
  logic [CNT_W-1:0] dwell_q;
  logic             max_hit;   // max-dwell error already reported this phase

  logic             code_valid;
  phase_t           code_phase;
  phase_t           legal_next;
  logic [CNT_W-1:0] min_cur;
  logic [CNT_W:0]   dwell_inc;
  logic             in_phase;
  logic             same_code;
  logic             onehot_d;
  logic             seq_d;
  logic             dwell_d;

  assign phase = state;
  assign dwell = dwell_q;

  // Decode the sampled bus into a phase; anything not exactly one-hot is invalid.
  always_comb begin
    code_valid = 1'b1;
    code_phase = IDLE;
    case (light)
      3'b100:  code_phase = RED;
      3'b010:  code_phase = GREEN;
      3'b001:  code_phase = YELLOW;
      default: code_valid = 1'b0;
    endcase
  end

  // Per-phase successor and minimum dwell, plus this cycle's error decisions.
  always_comb begin
    legal_next = IDLE;
    min_cur    = '0;
    case (state)
      RED:     begin legal_next = GREEN;  min_cur = MIN_RED_C;    end
      GREEN:   begin legal_next = YELLOW; min_cur = MIN_GREEN_C;  end
      YELLOW:  begin legal_next = RED;    min_cur = MIN_YELLOW_C; end
      default: begin legal_next = IDLE;   min_cur = '0;           end
    endcase
    dwell_inc = {1'b0, dwell_q} + 1'b1;
    in_phase  = code_valid && (state != IDLE);
    same_code = in_phase && (code_phase == state);
    onehot_d  = !code_valid;
    seq_d     = in_phase && (code_phase != state) && (code_phase != legal_next);
    dwell_d   = (same_code && !max_hit && (dwell_inc == MAX_P1)) ||
                (in_phase && (code_phase == legal_next) && (dwell_q < min_cur));
  end

  // Phase tracking FSM with dwell counter, cycle counter and registered error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dwell_q    <= '0;
      max_hit    <= 1'b0;
      cycle_cnt  <= 8'd0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_dwell  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_onehot <= onehot_d;
      err_seq    <= seq_d;
      err_dwell  <= dwell_d;
      // A new error takes priority over a simultaneous clear.
      if (onehot_d || seq_d || dwell_d) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end

      if (!code_valid) begin
        state   <= IDLE;
        dwell_q <= '0;
        max_hit <= 1'b0;
      end else if (same_code) begin
        if (dwell_inc > {1'b0, DWELL_SAT}) begin
          dwell_q <= DWELL_SAT;
        end else begin
          dwell_q <= dwell_inc[CNT_W-1:0];
        end
        if (dwell_inc == MAX_P1) begin
          max_hit <= 1'b1;
        end
      end else begin
        // Entry from IDLE, a legal step or a resync after an illegal step.
        state   <= code_phase;
        dwell_q <= CNT_W'(1);
        max_hit <= 1'b0;
        if ((state == YELLOW) && (code_phase == RED)) begin
          cycle_cnt <= cycle_cnt + 8'd1;
        end
      end
    end
  end

endmodule
